// File: rtl/sum4_serial_pkg.sv
// sum4_serial shared definitions
// datapath width and sequencer state encoding
package sum4_serial_pkg;

   localparam int DW = 16;

   typedef logic [DW-1:0] word_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADD_B = 3'd1,
      ADD_C = 3'd2,
      ADD_D = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/sum4_serial_if.sv
// sum4_serial operand/result handshake bundle
// master drives operands and out_ready, slave is the adder
interface sum4_serial_if;
   import sum4_serial_pkg::*;

   logic  in_valid;
   logic  in_ready;
   word_t a;
   word_t b;
   word_t c;
   word_t d;
   logic  out_valid;
   logic  out_ready;
   word_t sum;
   logic  busy;

   modport master (
      output in_valid,
      output a,
      output b,
      output c,
      output d,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  sum,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  c,
      input  d,
      input  out_ready,
      output in_ready,
      output out_valid,
      output sum,
      output busy
   );

endinterface

// File: rtl/sum4_serial_cla.sv
// 16-bit two-level carry look-ahead adder
// 4-bit groups, group carries resolved in parallel, carry out dropped
module carry_look_ahead_16bit
   import sum4_serial_pkg::*;
(
   input  word_t x,
   input  word_t y,
   output word_t s
);

   logic [15:0] p;
   logic [15:0] c;
   logic [14:0] g;
   logic [2:0]  gg;
   logic [2:1]  gp;
   logic [3:0]  cg;

   assign p = x ^ y;
   assign g = x[14:0] & y[14:0];

   for (genvar k = 0; k < 3; k++) begin : g_grp
      localparam int B = 4 * k;
      assign gg[k] = g[B+3]
                   | (p[B+3] & g[B+2])
                   | (p[B+3] & p[B+2] & g[B+1])
                   | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      if (k > 0) begin : g_prop
         assign gp[k] = &p[B+:4];
      end
   end

   assign cg[0] = 1'b0;
   assign cg[1] = gg[0];
   assign cg[2] = gg[1] | (gp[1] & gg[0]);
   assign cg[3] = gg[2]
                | (gp[2] & gg[1])
                | (gp[2] & gp[1] & gg[0]);

   for (genvar k = 0; k < 4; k++) begin : g_bit
      localparam int B = 4 * k;
      assign c[B]   = cg[k];
      assign c[B+1] = g[B] | (p[B] & cg[k]);
      assign c[B+2] = g[B+1]
                    | (p[B+1] & g[B])
                    | (p[B+1] & p[B] & cg[k]);
      assign c[B+3] = g[B+2]
                    | (p[B+2] & g[B+1])
                    | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & cg[k]);
   end

   assign s = p ^ c;

endmodule

// File: rtl/sum4_serial.sv
// sum4_serial: a+b+c+d over one shared adder
// a loads acc, then b, c, d are added on successive cycles
module sum4_serial
   import sum4_serial_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   sum4_serial_if.slave  io
);

   state_e state_q, state_d;
   word_t  acc_q, acc_d;
   word_t  b_q, b_d;
   word_t  c_q, c_d;
   word_t  d_q, d_d;
   word_t  add_rhs;
   word_t  add_sum;
   logic   accept;

   assign accept = io.in_valid && (state_q == IDLE);

   // pick the operand register that pairs with acc this cycle
   always_comb begin
      add_rhs = '0;
      unique case (state_q)
         ADD_B:   add_rhs = b_q;
         ADD_C:   add_rhs = c_q;
         ADD_D:   add_rhs = d_q;
         default: add_rhs = '0;
      endcase
   end

   carry_look_ahead_16bit u_add (
      .x (acc_q),
      .y (add_rhs),
      .s (add_sum)
   );

   // sequencer next state; stray encodings fall back to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (io.in_valid) state_d = ADD_B;
         ADD_B:   state_d = ADD_C;
         ADD_C:   state_d = ADD_D;
         ADD_D:   state_d = DONE;
         DONE:    if (io.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // capture operands on accept, accumulate in the add states
   always_comb begin
      acc_d = acc_q;
      b_d   = b_q;
      c_d   = c_q;
      d_d   = d_q;
      if (accept) begin
         acc_d = io.a;
         b_d   = io.b;
         c_d   = io.c;
         d_d   = io.d;
      end else if (state_q inside {ADD_B, ADD_C, ADD_D}) begin
         acc_d = add_sum;
      end
   end

   // state and datapath registers, reset wins over any handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
      end
   end

   // handshake and status outputs decoded from state
   always_comb begin
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      unique case (state_q)
         IDLE:    io.in_ready  = 1'b1;
         DONE:    io.out_valid = 1'b1;
         default: io.in_ready  = 1'b0;
      endcase
      io.busy = (state_q != IDLE);
      io.sum  = acc_q;
   end

endmodule

// File: tb/tb_sum4_serial.sv
// sum4_serial bench
// expected sums queued at accept, compared at result handshake
module tb_sum4_serial;
   import sum4_serial_pkg::*;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;
   int   n_out;
   int   cyc;
   int   c1;
   int   c2;
   int   n0;
   word_t exp_q[$];
   word_t mon_exp;

   sum4_serial_if io ();

   sum4_serial dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // result handshake happens on the coming edge; score it now
   always @(negedge clk) begin
      if (!rst && io.out_valid && io.out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(io.sum), 32'hFFFF_FFFF);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("sum", 32'(io.sum), 32'(mon_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input word_t a, input word_t b,
                       input word_t c, input word_t d,
                       input bit keep, output int acc_cyc);
      bit    ok;
      word_t e;
      ok = 1'b0;
      io.in_valid = 1'b1;
      io.a = a;
      io.b = b;
      io.c = c;
      io.d = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (io.in_ready && !rst) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (ok) begin
         e = a + b + c + d;
         exp_q.push_back(e);
      end else begin
         chk("accept_timeout", 32'd0, 32'd1);
      end
      if (!keep) io.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      n_out = 0;
      cyc   = 0;
      rst   = 1'b1;
      io.in_valid  = 1'b1;
      io.out_ready = 1'b0;
      io.a = 16'd7;
      io.b = 16'd7;
      io.c = 16'd7;
      io.d = 16'd7;

      // reset with in_valid high must not accept
      repeat (3) tick();
      chk("rst_rdy",  32'(io.in_ready),  32'd1);
      chk("rst_busy", 32'(io.busy),      32'd0);
      chk("rst_ov",   32'(io.out_valid), 32'd0);
      chk("rst_sum",  32'(io.sum),       32'd0);
      io.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("idle_busy", 32'(io.busy), 32'd0);

      // latency and accumulator progression
      io.out_ready = 1'b1;
      send(16'd56, 16'd224, 16'd224, 16'd896, 1'b0, c1);
      chk("lat_busy", 32'(io.busy),      32'd1);
      chk("lat_rdy",  32'(io.in_ready),  32'd0);
      chk("lat_ov0",  32'(io.out_valid), 32'd0);
      chk("acc_a",    32'(io.sum),       32'd56);
      tick();
      chk("lat_ov1",  32'(io.out_valid), 32'd0);
      chk("acc_ab",   32'(io.sum),       32'd280);
      tick();
      chk("lat_ov2",  32'(io.out_valid), 32'd0);
      chk("acc_abc",  32'(io.sum),       32'd504);
      tick();
      chk("lat_ov3",  32'(io.out_valid), 32'd1);
      chk("lat_sum",  32'(io.sum),       32'd1400);
      tick();
      chk("back_idle", 32'(io.in_ready),  32'd1);
      chk("back_ov",   32'(io.out_valid), 32'd0);
      chk("back_busy", 32'(io.busy),      32'd0);

      // back-to-back with in_valid held high
      send(16'd14, 16'd1, 16'd224, 16'd896, 1'b1, c1);
      send(16'd999, 16'd0, 16'd224, 16'd896, 1'b0, c2);
      chk("b2b_gap", 32'(c2 - c1), 32'd5);
      drain();

      // modulo wrap
      send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, c1);
      drain();

      // result held under back-pressure, single completion
      io.out_ready = 1'b0;
      send(16'd5, 16'd0, 16'd224, 16'd896, 1'b0, c1);
      repeat (3) tick();
      for (int i = 0; i < 10; i++) begin
         chk("hold_ov",  32'(io.out_valid), 32'd1);
         chk("hold_sum", 32'(io.sum),       32'd1125);
         tick();
      end
      n0 = n_out;
      io.out_ready = 1'b1;
      drain();
      repeat (3) tick();
      chk("hold_once", 32'(n_out - n0), 32'd1);

      // reset while in ADD_C discards the operation
      send(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, c1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      chk("mid_ov",   32'(io.out_valid), 32'd0);
      chk("mid_sum",  32'(io.sum),       32'd0);
      chk("mid_rdy",  32'(io.in_ready),  32'd1);
      chk("mid_busy", 32'(io.busy),      32'd0);
      n0 = n_out;
      repeat (6) tick();
      chk("mid_noout", 32'(n_out - n0), 32'd0);
      send(16'd56, 16'd224, 16'd224, 16'd896, 1'b0, c1);
      drain();

      // noise on the inputs while busy is ignored
      io.out_ready = 1'b0;
      send(16'd100, 16'd200, 16'd300, 16'd400, 1'b0, c1);
      for (int i = 0; i < 6; i++) begin
         io.in_valid = ~io.in_valid;
         io.a = 16'($urandom);
         io.b = 16'($urandom);
         io.c = 16'($urandom);
         io.d = 16'($urandom);
         tick();
      end
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      drain();

      // random sets against the bench model
      for (int i = 0; i < 8; i++) begin
         send(16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 1'b0, c1);
      end
      drain();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
